// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction scheduler: response status codes
// and the scheduler state encoding.
package i2c_pkg;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_NACK = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PUSH  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/i2c_rr_arb.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// requesting index found after 'last', wrapping modulo NREQ.
module i2c_rr_arb #(
  parameter int NREQ = 2,
  parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] gnt
);

  logic          found;
  logic [LW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = LW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_sched.sv
// Round-robin scheduler granting one requester a whole transaction: pushes its
// words into the TX FIFO, starts the core, supervises completion and reports status.
//
// state | meaning
// IDLE  | no owner, arbitrate among req_valid
// PUSH  | owner's words flow into the TX FIFO until req_last
// START | one-cycle core start, arm timeout
// WAIT  | wait for i2c_done or timeout
// RESP  | one-cycle status pulse to the owner
module i2c_txn_sched
  import i2c_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int TOW  = 14
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    grant,
  input  logic               tx_full,
  output logic               wr_ena_tx,
  output logic [DW-1:0]      write_data_on_tx,
  output logic               i2c_start,
  input  logic               i2c_done,
  input  logic               error,
  input  logic               response_ack_nack,
  input  logic [TOW-1:0]     timeout_cfg,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [1:0]         rsp_status,
  output logic               busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q;
  logic [NREQ-1:0] grant_q;
  logic [LW-1:0]   owner_q;
  logic [LW-1:0]   last_owner_q;
  logic [TOW-1:0]  cnt_q;
  logic [TOW-1:0]  to_lim_q;
  logic            start_q;
  logic            busy_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [1:0]      rsp_status_q;

  logic [NREQ-1:0] arb_gnt;
  logic [LW-1:0]   arb_idx_d;
  logic            in_push;
  logic            xfer;

  i2c_rr_arb #(.NREQ(NREQ), .LW(LW)) u_arb (
    .req  (req_valid),
    .last (last_owner_q),
    .gnt  (arb_gnt)
  );

  always_comb begin
    arb_idx_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) arb_idx_d = LW'(i);
    end
  end

  // Handshake and FIFO write are combinational so a word moves in the cycle it is offered.
  assign in_push          = (state_q == S_PUSH);
  assign xfer             = in_push && !tx_full && req_valid[owner_q];
  assign req_ready        = (in_push && !tx_full) ? grant_q : '0;
  assign wr_ena_tx        = xfer;
  assign write_data_on_tx = xfer ? req_data[int'(owner_q)*DW +: DW] : '0;

  assign grant      = grant_q;
  assign i2c_start  = start_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= LW'(NREQ - 1);
      cnt_q        <= '0;
      to_lim_q     <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req_valid) begin
            grant_q <= arb_gnt;
            owner_q <= arb_idx_d;
            busy_q  <= 1'b1;
            state_q <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (xfer && req_last[owner_q]) begin
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          start_q  <= 1'b0;
          to_lim_q <= timeout_cfg;
          cnt_q    <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + TOW'(1);
          // Done outranks a timeout landing in the same cycle.
          if (i2c_done) begin
            rsp_valid_q  <= grant_q;
            rsp_status_q <= error ? ST_ERR : (response_ack_nack ? ST_NACK : ST_OK);
            state_q      <= S_RESP;
          end else if ((to_lim_q != '0) && (cnt_q == to_lim_q - TOW'(1))) begin
            rsp_valid_q  <= grant_q;
            rsp_status_q <= ST_TMO;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid_q  <= '0;
          rsp_status_q <= ST_OK;
          last_owner_q <= owner_q;
          grant_q      <= '0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sched.sv
// Scoreboard bench for i2c_txn_sched: directed transactions push expected FIFO
// writes, starts and responses; a negedge monitor pops and compares them.
module tb_i2c_txn_sched;
  import i2c_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int TOW  = 14;

  logic               pclk = 1'b0;
  logic               preset = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_last = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    grant;
  logic               tx_full = 1'b0;
  logic               wr_ena_tx;
  logic [DW-1:0]      write_data_on_tx;
  logic               i2c_start;
  logic               i2c_done = 1'b0;
  logic               error = 1'b0;
  logic               response_ack_nack = 1'b0;
  logic [TOW-1:0]     timeout_cfg = '0;
  logic [NREQ-1:0]    rsp_valid;
  logic [1:0]         rsp_status;
  logic               busy;

  i2c_txn_sched #(.NREQ(NREQ), .DW(DW), .TOW(TOW)) dut (
    .pclk              (pclk),
    .preset            (preset),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_last          (req_last),
    .req_ready         (req_ready),
    .grant             (grant),
    .tx_full           (tx_full),
    .wr_ena_tx         (wr_ena_tx),
    .write_data_on_tx  (write_data_on_tx),
    .i2c_start         (i2c_start),
    .i2c_done          (i2c_done),
    .error             (error),
    .response_ack_nack (response_ack_nack),
    .timeout_cfg       (timeout_cfg),
    .rsp_valid         (rsp_valid),
    .rsp_status        (rsp_status),
    .busy              (busy)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc++;

  typedef struct {
    int              kind;   // 0 write, 1 start, 2 response
    logic [DW-1:0]   data;
    logic [NREQ-1:0] vec;
    logic [1:0]      st;
    int              lat;    // cycles from i2c_start to rsp_valid, -1 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int nvec = 0;
  int nerr = 0;
  int start_cyc = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void bound_fail(string name);
    nvec++;
    nerr++;
    $display("FAIL %s: got no event expected one within budget (t=%0t)", name, $time);
  endfunction

  function automatic void exp_wr(logic [DW-1:0] d);
    exp_q.push_back('{0, d, '0, 2'b00, -1});
  endfunction

  function automatic void exp_start();
    exp_q.push_back('{1, '0, '0, 2'b00, -1});
  endfunction

  function automatic void exp_rsp(logic [NREQ-1:0] v, logic [1:0] st, int lat);
    exp_q.push_back('{2, '0, v, st, lat});
  endfunction

  // Monitor: every DUT output event consumes the next expected entry.
  exp_t e;
  always @(negedge pclk) begin
    if (!preset) begin
      if (grant != '0) chk("grant_onehot", $countones(grant), 1);
      if (wr_ena_tx) begin
        if (exp_q.size() == 0) bound_fail("unexpected_write");
        else begin
          e = exp_q.pop_front();
          chk("write_order", e.kind, 0);
          chk("write_data", write_data_on_tx, e.data);
        end
      end
      if (i2c_start) begin
        start_cyc = cyc;
        if (exp_q.size() == 0) bound_fail("unexpected_start");
        else begin
          e = exp_q.pop_front();
          chk("start_order", e.kind, 1);
        end
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) bound_fail("unexpected_rsp");
        else begin
          e = exp_q.pop_front();
          chk("rsp_order", e.kind, 2);
          chk("rsp_valid", rsp_valid, e.vec);
          chk("rsp_status", rsp_status, e.st);
          if (e.lat >= 0) chk("rsp_latency", cyc - start_cyc, e.lat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push_word(int r, logic [DW-1:0] d, bit last);
    bit x;
    int n;
    n = 0;
    req_valid[r] = 1'b1;
    req_data[r*DW +: DW] = d;
    req_last[r] = last;
    do begin
      @(negedge pclk);
      x = req_ready[r];
      tick();
      n++;
    end while (!x && n < 300);
    if (!x) bound_fail("push_word_accept");
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!i2c_start && n < 300);
    if (!i2c_start) bound_fail("wait_start");
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (rsp_valid == '0 && n < 300);
    if (rsp_valid == '0) bound_fail("wait_rsp");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (busy && n < 300);
    if (busy) bound_fail("wait_idle");
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (grant == '0 && n < 300);
    if (grant == '0) bound_fail("wait_grant");
  endtask

  // Called right after i2c_start is seen at a negedge; done lands dly cycles into WAIT.
  task automatic send_done(int dly, bit er, bit nk);
    repeat (dly + 1) tick();
    i2c_done = 1'b1;
    error = er;
    response_ack_nack = nk;
    tick();
    i2c_done = 1'b0;
    error = 1'b0;
    response_ack_nack = 1'b0;
  endtask

  task automatic do_txn(int r, int nw, logic [DW-1:0] base, int dly, bit er, bit nk,
                        logic [1:0] st);
    for (int i = 0; i < nw; i++) exp_wr(base + DW'(i));
    exp_start();
    exp_rsp(NREQ'(1) << r, st, dly + 2);
    for (int i = 0; i < nw; i++) push_word(r, base + DW'(i), i == nw - 1);
    req_valid[r] = 1'b0;
    req_last[r] = 1'b0;
    wait_start();
    send_done(dly, er, nk);
    wait_idle();
  endtask

  function automatic logic [63:0] all_outs();
    return {21'd0, req_ready, grant, wr_ena_tx, write_data_on_tx, i2c_start,
            rsp_valid, rsp_status, busy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    #2;
    chk("reset_outputs_initial", all_outs(), 64'd0);
    tick();
    tick();
    preset = 1'b0;

    // Single requester, three words, clean completion.
    do_txn(0, 3, 32'hA1, 0, 1'b0, 1'b0, ST_OK);
    // Slave NACK only.
    do_txn(1, 1, 32'hD1, 1, 1'b0, 1'b1, ST_NACK);

    // Both requesters always valid, one-word transactions: grants alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      exp_wr((k % 2 == 0) ? 32'hB0 : 32'hB1);
      exp_start();
      exp_rsp((k % 2 == 0) ? 2'b01 : 2'b10, ST_OK, 2);
    end
    req_data  = {32'hB1, 32'hB0};
    req_last  = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_start();
      send_done(0, 1'b0, 1'b0);
      wait_rsp();
    end
    tick();
    req_valid = '0;
    req_last  = '0;
    wait_idle();

    // Back-pressure on the second word.
    fork
      do_txn(0, 3, 32'hC1, 0, 1'b0, 1'b0, ST_OK);
      begin
        int n;
        n = 0;
        do begin
          @(negedge pclk);
          n++;
        end while (!wr_ena_tx && n < 300);
        if (!wr_ena_tx) bound_fail("first_word_for_full");
        tick();
        tx_full = 1'b1;
        repeat (5) begin
          @(negedge pclk);
          chk("full_req_ready", req_ready, 2'b00);
          chk("full_no_write", wr_ena_tx, 0);
        end
        tick();
        tx_full = 1'b0;
        @(negedge pclk);
        chk("write_on_full_release", wr_ena_tx, 1);
      end
    join

    // Error and NACK together: error wins.
    do_txn(0, 1, 32'hD2, 0, 1'b1, 1'b1, ST_ERR);

    // Done in the same cycle the 4-cycle timeout would fire.
    timeout_cfg = 14'd4;
    do_txn(0, 1, 32'hE1, 3, 1'b0, 1'b0, ST_OK);

    // Timeout of 10 with no done.
    timeout_cfg = 14'd10;
    exp_wr(32'hF1);
    exp_start();
    exp_rsp(2'b01, ST_TMO, 11);
    push_word(0, 32'hF1, 1'b1);
    req_valid = '0;
    req_last  = '0;
    wait_start();
    wait_idle();

    // Timeout disabled: stays in WAIT, then reset lands mid-WAIT.
    timeout_cfg = 14'd0;
    exp_wr(32'hF2);
    exp_start();
    push_word(0, 32'hF2, 1'b1);
    req_valid = '0;
    req_last  = '0;
    wait_start();
    repeat (1000) @(negedge pclk);
    chk("tmo0_still_busy", busy, 1);
    chk("tmo0_no_rsp_pending", exp_q.size(), 0);
    preset = 1'b1;
    #1;
    chk("reset_outputs_wait", all_outs(), 64'd0);
    req_data  = {32'h61, 32'h60};
    req_last  = 2'b11;
    req_valid = 2'b11;
    tick();
    tick();
    preset = 1'b0;
    exp_wr(32'h60);
    exp_start();
    exp_rsp(2'b01, ST_OK, 2);
    wait_grant();
    chk("grant_after_reset_wait", grant, 2'b01);
    tick();
    req_valid = '0;
    req_last  = '0;
    wait_start();
    send_done(0, 1'b0, 1'b0);
    wait_idle();

    // Reset mid-PUSH of requester 1 (last owner 0 would otherwise favour 1).
    exp_wr(32'h71);
    req_data[DW +: DW] = 32'h71;
    req_last[1] = 1'b0;
    req_valid[1] = 1'b1;
    wait_grant();
    tick();
    req_valid[1] = 1'b0;
    repeat (3) tick();
    chk("push_stalled_busy", busy, 1);
    preset = 1'b1;
    req_data = {32'h73, 32'h72};
    req_last = 2'b11;
    req_valid = 2'b11;
    #1;
    chk("reset_outputs_push", all_outs(), 64'd0);
    tick();
    tick();
    preset = 1'b0;
    exp_wr(32'h72);
    exp_start();
    exp_rsp(2'b01, ST_OK, 2);
    wait_grant();
    chk("grant_after_reset_push", grant, 2'b01);
    tick();
    req_valid = '0;
    req_last  = '0;
    wait_start();
    send_done(0, 1'b0, 1'b0);
    wait_idle();

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
